// File: rtl/bcid_counter_sync.sv
// BCID counter with master/slave start, configurable wrap and prescaler.
// Checked-slave mode tracks alignment to BcidIn and resynchronises after repeated mismatches.
module bcid_counter_sync #(
  parameter int BCID_WIDTH    = 9,
  parameter int PRESCALE_BITS = 2,
  parameter int BCID_MAX      = 511,
  parameter int ERR_CNT_WIDTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     ResetLatency,
  input  logic [BCID_WIDTH-1:0]    BcidIn,
  input  logic [BCID_WIDTH-1:0]    CONF_LATENCY,
  input  logic [PRESCALE_BITS-1:0] CONF_PRESCALER,
  input  logic [1:0]               CONF_MODE,
  input  logic [ERR_CNT_WIDTH-1:0] CONF_RESYNC_THR,
  output logic [BCID_WIDTH-1:0]    BcidOut,
  output logic                     BcidTick,
  output logic                     Running,
  output logic                     Locked,
  output logic                     SyncError,
  output logic [ERR_CNT_WIDTH-1:0] ErrCount,
  output logic                     Resync
);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [BCID_WIDTH-1:0]    MAX_V   = BCID_MAX[BCID_WIDTH-1:0];
  localparam logic [BCID_WIDTH:0]      MOD_V   = (BCID_WIDTH+1)'(BCID_MAX + 1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_SAT = '1;

  logic [0:0]               state;
  logic [PRESCALE_BITS-1:0] presc;
  logic [ERR_CNT_WIDTH-1:0] cons_cnt;
  logic                     locked_chk;

  logic                     clr, tick, mode_master, mode_chk, start, aligned, resync_fire;
  logic [BCID_WIDTH-1:0]    bcid_inc;
  logic [BCID_WIDTH:0]      exp_w;
  logic [ERR_CNT_WIDTH-1:0] cons_inc, err_inc;

  assign clr         = Reset | ResetLatency;
  // >= rather than == so a lowered prescale setting cannot strand the counter above it
  assign tick        = (presc >= CONF_PRESCALER);
  assign mode_master = (CONF_MODE == 2'd0);
  assign mode_chk    = CONF_MODE[1];
  assign start       = mode_master | (BcidIn == CONF_LATENCY);
  assign bcid_inc    = (BcidOut == MAX_V) ? '0 : BcidOut + BCID_WIDTH'(1);

  // Expected local BCID = (BcidIn - latency) mod (BCID_MAX+1), one extra bit for the wrap term
  always_comb begin
    exp_w = '0;
    if (BcidIn >= CONF_LATENCY)
      exp_w = {1'b0, BcidIn} - {1'b0, CONF_LATENCY};
    else
      exp_w = {1'b0, BcidIn} + MOD_V - {1'b0, CONF_LATENCY};
  end

  assign aligned     = ({1'b0, BcidOut} == exp_w);
  assign cons_inc    = (cons_cnt == ERR_SAT) ? cons_cnt : cons_cnt + ERR_CNT_WIDTH'(1);
  assign err_inc     = (ErrCount == ERR_SAT) ? ErrCount : ErrCount + ERR_CNT_WIDTH'(1);
  assign resync_fire = (CONF_RESYNC_THR != '0) && (cons_inc >= CONF_RESYNC_THR);

  assign Running = (state == ST_RUN);
  assign Locked  = mode_chk ? locked_chk : Running;

  always_ff @(posedge Clk) begin
    if (clr) begin
      state      <= ST_WAIT;
      presc      <= '0;
      BcidOut    <= '0;
      BcidTick   <= 1'b0;
      cons_cnt   <= '0;
      locked_chk <= 1'b0;
      SyncError  <= 1'b0;
      ErrCount   <= '0;
      Resync     <= 1'b0;
    end else begin
      BcidTick <= 1'b0;
      Resync   <= 1'b0;
      if (!mode_chk) cons_cnt <= '0;

      if (tick) begin
        presc <= '0;
        if (state == ST_WAIT) begin
          if (start) begin
            state    <= ST_RUN;
            BcidOut  <= bcid_inc;
            BcidTick <= 1'b1;
          end
        end else begin
          BcidOut  <= bcid_inc;
          BcidTick <= 1'b1;
          if (mode_chk) begin
            if (aligned) begin
              cons_cnt   <= '0;
              locked_chk <= 1'b1;
            end else begin
              SyncError  <= 1'b1;
              ErrCount   <= err_inc;
              locked_chk <= 1'b0;
              cons_cnt   <= cons_inc;
              // Too many misses in a row: drop back and wait for the start BCID again
              if (resync_fire) begin
                state    <= ST_WAIT;
                BcidOut  <= '0;
                cons_cnt <= '0;
                Resync   <= 1'b1;
              end
            end
          end
        end
      end else begin
        presc <= presc + PRESCALE_BITS'(1);
      end
    end
  end

endmodule
